pipe_regs: RTL

- Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each stage with its own valid bit, and ready/valid handshakes on both ends.
- Successor to the plain enabled/resettable flop. Adds:
  - per-stage bubble collapsing
  - backpressure
  - synchronous flush
  - global enable
  - occupancy count
- Used between datapath units wherever a timing stage is needed that must also tolerate downstream stalls.

---
 rtl/pipe_regs.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_regs.sv
// pipe_regs: elastic pipeline register with DEPTH stages of WIDTH-bit data.
// Each stage has its own valid bit. Empty stages take new data even while the
// output is stalled (bubble collapsing). There is a global enable, a
// synchronous flush and a registered occupancy count.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   en         global enable; 0 freezes all state and blocks both handshakes
//   flush      synchronous flush (needs en=1); invalidates every stage
//   in_valid   upstream data valid
//   in_data    upstream data [WIDTH-1:0]
//   in_ready   block accepts in_data this cycle (combinational from out_ready)
//   out_valid  out_data is valid
//   out_data   last-stage data [WIDTH-1:0], not gated by valid
//   out_ready  downstream accepts out_data this cycle
//   count      number of valid stages [CW-1:0]

// One pipeline stage: a valid flag plus a data register. Data is written only
// when the incoming word is valid, so a bubble does not overwrite the data.
module pipe_regs_stage #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_adv,
    input  logic             i_src_vld,
    input  logic [WIDTH-1:0] i_src_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);
    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld  <= 1'b0;
            r_data <= INIT;
        end else if (i_flush) begin
            r_vld  <= 1'b0;
        end else if (i_adv) begin
            r_vld  <= i_src_vld;
            if (i_src_vld) r_data <= i_src_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
endmodule

module pipe_regs #(
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);
    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_regs: DEPTH must be >= 1");
    end

    logic                        w_go;
    logic                        w_flush;
    logic [DEPTH:0]              w_adv;
    logic [DEPTH-1:0]            w_vld;
    logic [DEPTH-1:0][WIDTH-1:0] w_data;
    logic                        w_in_hs;
    logic                        w_out_hs;
    logic [CW-1:0]               r_count;

    assign w_go    = en & ~flush;
    assign w_flush = en & flush;

    // Advance terms, computed back to front inside one process so the chain
    // from out_ready to in_ready stays a plain combinational ripple.
    always_comb begin
        w_adv        = '0;
        w_adv[DEPTH] = out_ready & w_go;
        for (int k = DEPTH - 1; k >= 0; k--)
            w_adv[k] = w_go & (~w_vld[k] | w_adv[k+1]);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_src_vld;
        logic [WIDTH-1:0] w_src_data;

        if (k == 0) begin : g_head
            assign w_src_vld  = in_valid;
            assign w_src_data = in_data;
        end else begin : g_body
            assign w_src_vld  = w_vld[k-1];
            assign w_src_data = w_data[k-1];
        end

        pipe_regs_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .i_flush    (w_flush),
            .i_adv      (w_adv[k]),
            .i_src_vld  (w_src_vld),
            .i_src_data (w_src_data),
            .o_vld      (w_vld[k]),
            .o_data     (w_data[k])
        );
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_vld[DEPTH-1] & w_go;
    assign out_data  = w_data[DEPTH-1];

    assign w_in_hs  = in_valid & w_adv[0];
    assign w_out_hs = w_vld[DEPTH-1] & w_adv[DEPTH];

    // Occupancy tracks handshakes; both or neither leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (w_flush)
            r_count <= '0;
        else if (w_in_hs & ~w_out_hs)
            r_count <= r_count + CW'(1);
        else if (w_out_hs & ~w_in_hs)
            r_count <= r_count - CW'(1);
    end

    assign count = r_count;
endmodule
